// File: rtl/result_uart_tx_pkg.sv
// Shared types and constants for the result-memory UART reader.
// RESULT_TX_SYNC_HEADER_EN adds the two header states to the state enum.
package result_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
`ifdef RESULT_TX_SYNC_HEADER_EN
    , HDR0,
    HDR1
`endif
  } state_t;

  localparam logic       UART_START_BIT = 1'b0;
  localparam logic       UART_STOP_BIT  = 1'b1;
  localparam logic [7:0] SYNC_BYTE0     = 8'hAA;
  localparam logic [7:0] SYNC_BYTE1     = 8'h55;

endpackage

// File: rtl/result_uart_tx_if.sv
// Result-memory read port, start/status handshake and TX line of result_uart_tx.
// master = the reader, slave = memory/host side.
interface result_uart_tx_if #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8
);
  logic                   iStart;
  logic [WIDTH_BITS-1:0]  oResultCol;
  logic [HEIGHT_BITS-1:0] oResultRow;
  logic                   iResultData;
  logic                   oTx;
  logic                   oBusy;
  logic                   oDone;

  modport master (
    input  iStart, iResultData,
    output oResultCol, oResultRow, oTx, oBusy, oDone
  );

  modport slave (
    output iStart, iResultData,
    input  oResultCol, oResultRow, oTx, oBusy, oDone
  );
endinterface

// File: rtl/result_uart_tx_byte.sv
// 8N1 byte serializer: start bit, LSB-first data, stop bit, each CLKS_PER_BIT cycles.
// oReady is also high in the last stop-bit cycle so frames can run back to back.
module uart_tx_byte
  import result_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iValid,
  input  logic [7:0] iData,
  output logic       oReady,
  output logic       oTx
);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  logic          busy;
  logic [TW-1:0] timer;
  logic [3:0]    bit_idx;
  logic [7:0]    shreg;

  assign oReady = !busy || (timer == T_LAST && bit_idx == 4'd9);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      oTx     <= UART_STOP_BIT;
    end else if (oReady && iValid) begin
      busy    <= 1'b1;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= iData;
      oTx     <= UART_START_BIT;
    end else if (busy) begin
      if (timer == T_LAST) begin
        timer <= '0;
        if (bit_idx == 4'd9) begin
          busy <= 1'b0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          // bit_idx 1..8 carry data bits 0..7, 9 is the stop bit
          if (bit_idx == 4'd8) begin
            oTx <= UART_STOP_BIT;
          end else begin
            oTx   <= shreg[0];
            shreg <= shreg >> 1;
          end
        end
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end
endmodule

// File: rtl/result_uart_tx.sv
// Scans the 1-bit result memory in raster order, packs 8 pixels MSB-first and sends each byte 8N1.
// RESULT_TX_SYNC_HEADER_EN: prefix the image with sync bytes 0xAA, 0x55.
//
// state | meaning
// IDLE  | wait for iStart, pos = 0
// HDR0  | hand sync byte 0xAA to the serializer (macro only)
// HDR1  | hand sync byte 0x55 once the 0xAA frame ends (macro only)
// FETCH | 9 cycles: present 8 addresses, capture 8 pixels
// SEND  | wait for the current frame to finish its stop bit
// DONE  | image sent, wait for iStart low
module result_uart_tx
  import result_tx_pkg::*;
#(
  parameter int WIDTH_BITS   = 8,
  parameter int HEIGHT_BITS  = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input logic               clock,
  input logic               reset,
  result_uart_tx_if.master  bus
);
  localparam int PW = WIDTH_BITS + HEIGHT_BITS;

  state_t        state;
  logic [PW-1:0] pos;
  logic [3:0]    fetch_cnt;
  logic [7:0]    pack;
  logic          last_grp;
  logic          busy_r;
  logic          done_r;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;

  // The eighth pixel is taken straight off the RAM so the byte loads on the last FETCH edge.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = pack;
    case (state)
      FETCH: begin
        if (fetch_cnt == 4'd8) begin
          tx_valid = 1'b1;
          tx_data  = {pack[6:0], bus.iResultData};
        end
      end
`ifdef RESULT_TX_SYNC_HEADER_EN
      HDR0: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE0;
      end
      HDR1: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pos       <= '0;
      fetch_cnt <= '0;
      pack      <= '0;
      last_grp  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          fetch_cnt <= '0;
          last_grp  <= 1'b0;
          if (bus.iStart) begin
            busy_r <= 1'b1;
`ifdef RESULT_TX_SYNC_HEADER_EN
            state  <= HDR0;
`else
            state  <= FETCH;
`endif
          end
        end
`ifdef RESULT_TX_SYNC_HEADER_EN
        HDR0: if (tx_ready) state <= HDR1;
        HDR1: if (tx_ready) state <= SEND;
`endif
        FETCH: begin
          if (fetch_cnt < 4'd8) pos <= pos + PW'(1);
          if (fetch_cnt == 4'd7) last_grp <= (pos == '1);
          if (fetch_cnt >= 4'd1) pack <= {pack[6:0], bus.iResultData};
          fetch_cnt <= fetch_cnt + 4'd1;
          if (fetch_cnt == 4'd8) state <= SEND;
        end
        SEND: begin
          fetch_cnt <= '0;
          if (tx_ready) begin
            if (last_grp) begin
              state    <= DONE;
              busy_r   <= 1'b0;
              done_r   <= 1'b1;
              pos      <= '0;
              last_grp <= 1'b0;
            end else begin
              state <= FETCH;
            end
          end
        end
        DONE: begin
          if (!bus.iStart) begin
            state  <= IDLE;
            done_r <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oResultCol = pos[WIDTH_BITS-1:0];
  assign bus.oResultRow = pos[PW-1:WIDTH_BITS];
  assign bus.oBusy      = busy_r;
  assign bus.oDone      = done_r;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clock  (clock),
    .reset  (reset),
    .iValid (tx_valid),
    .iData  (tx_data),
    .oReady (tx_ready),
    .oTx    (bus.oTx)
  );
endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx: 8x2 image, 4 clocks/bit, plus a 434 clocks/bit instance for bit timing.
module tb_result_uart_tx;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  result_uart_tx_if #(.WIDTH_BITS(3), .HEIGHT_BITS(1)) bus_f ();
  result_uart_tx_if #(.WIDTH_BITS(3), .HEIGHT_BITS(1)) bus_s ();

  result_uart_tx #(.WIDTH_BITS(3), .HEIGHT_BITS(1), .CLKS_PER_BIT(4)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_f)
  );

  result_uart_tx #(.WIDTH_BITS(3), .HEIGHT_BITS(1), .CLKS_PER_BIT(434)) u_slow (
    .clock (clock),
    .reset (reset),
    .bus   (bus_s)
  );

  // mem[address], address = {row, col}; synchronous read
  logic [15:0] mem = '0;
  always @(posedge clock) begin
    bus_f.iResultData <= mem[{bus_f.oResultRow, bus_f.oResultCol}];
    bus_s.iResultData <= mem[{bus_s.oResultRow, bus_s.oResultCol}];
  end

  typedef struct {
    logic [15:0] mem;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  vec_t vecs[5];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  task automatic tick();
    @(negedge clock);
    cyc++;
  endtask

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clock);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Decode the expected frames of one transmission started at negedge c0 (4 clocks/bit).
  task automatic expect_stream(int c0, logic [7:0] b0, logic [7:0] b1);
    logic [7:0] exp_q[$];
    int         off_q[$];
    int         s;
    logic [7:0] d;
`ifdef RESULT_TX_SYNC_HEADER_EN
    exp_q = '{8'hAA, 8'h55, b0, b1};
    off_q = '{2, 42, 91, 140};
`else
    exp_q = '{b0, b1};
    off_q = '{10, 59};
`endif
    s = -1;
    for (int j = 0; j < exp_q.size(); j++) begin
      s = -1;
      while (s < 0 && cyc < c0 + off_q[j] + 20) begin
        if (bus_f.oTx === 1'b0) s = cyc;
        else tick();
      end
      check($sformatf("start_cycle[%0d]", j), (s < 0) ? -1 : s - c0, off_q[j]);
      if (s < 0) return;
      repeat (2) tick();
      check($sformatf("start_bit[%0d]", j), int'(bus_f.oTx), 0);
      for (int i = 0; i < 8; i++) begin
        repeat (4) tick();
        d[i] = bus_f.oTx;
      end
      repeat (4) tick();
      check($sformatf("byte[%0d]", j), int'(d), int'(exp_q[j]));
      check($sformatf("stop_bit[%0d]", j), int'(bus_f.oTx), 1);
    end
    tick();
    check("done_before_stop_end", int'(bus_f.oDone), 0);
    tick();
    check("done_after_stop", int'(bus_f.oDone), 1);
    check("busy_in_done", int'(bus_f.oBusy), 0);
  endtask

  task automatic quiet_hold(string name);
    int bad = 0;
    repeat (60) begin
      tick();
      if (bus_f.oTx !== 1'b1 || bus_f.oBusy !== 1'b0 || bus_f.oDone !== 1'b1) bad++;
    end
    check(name, bad, 0);
  endtask

  initial begin
    int c0, s, w, t0, t1, bad;
    logic [7:0] bit3_exp;

    // pixels listed col0..col7; address 0 is the LSB of mem
    vecs[0] = '{mem: 16'hFF8D, b0: 8'hB1, b1: 8'hFF};
    vecs[1] = '{mem: 16'h0000, b0: 8'h00, b1: 8'h00};
    vecs[2] = '{mem: 16'hAA55, b0: 8'hAA, b1: 8'h55};
    vecs[3] = '{mem: 16'h8001, b0: 8'h80, b1: 8'h01};
    vecs[4] = '{mem: 16'h0F53, b0: 8'hCA, b1: 8'hF0};

    bus_f.iStart = 1'b0;
    bus_s.iStart = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    bad = 0;
    repeat (100) begin
      tick();
      if (bus_f.oTx !== 1'b1 || bus_f.oBusy !== 1'b0 || bus_f.oDone !== 1'b0 ||
          bus_f.oResultCol !== 3'd0 || bus_f.oResultRow !== 1'd0) bad++;
    end
    check("reset_tx", int'(bus_f.oTx), 1);
    check("reset_busy", int'(bus_f.oBusy), 0);
    check("reset_done", int'(bus_f.oDone), 0);
    check("reset_addr", int'({bus_f.oResultRow, bus_f.oResultCol}), 0);
    check("reset_idle_stable", bad, 0);

    for (int v = 0; v < 5; v++) begin
      mem = vecs[v].mem;
      reset_pulse();
      tick();
      bus_f.iStart = 1'b1;
      c0 = cyc;
      check("busy_before_start", int'(bus_f.oBusy), 0);
      tick();
      check("busy_rise", int'(bus_f.oBusy), 1);
      expect_stream(c0, vecs[v].b0, vecs[v].b1);
      quiet_hold("held_start_no_resend");
      bus_f.iStart = 1'b0;
      tick();
    end

    // iStart stays high through DONE, then a one-cycle drop restarts
    mem = vecs[0].mem;
    reset_pulse();
    tick();
    bus_f.iStart = 1'b1;
    c0 = cyc;
    expect_stream(c0, 8'hB1, 8'hFF);
    quiet_hold("restart_quiet");
    bus_f.iStart = 1'b0;
    tick();
    bus_f.iStart = 1'b1;
    c0 = cyc;
    expect_stream(c0, 8'hB1, 8'hFF);
    bus_f.iStart = 1'b0;
    tick();

    // async reset during data bit 3 of the first frame
    reset_pulse();
    tick();
    bus_f.iStart = 1'b1;
    c0 = cyc;
    s = -1;
    while (s < 0 && cyc < c0 + 40) begin
      if (bus_f.oTx === 1'b0) s = cyc;
      else tick();
    end
    check("midreset_first_start", (s < 0) ? -1 : s - c0,
`ifdef RESULT_TX_SYNC_HEADER_EN
          2);
    bit3_exp = 8'hAA;
`else
          10);
    bit3_exp = 8'hB1;
`endif
    if (s >= 0) begin
      while (cyc < s + 17) tick();
      check("midreset_bit3", int'(bus_f.oTx), int'(bit3_exp[3]));
      #1 reset = 1'b1;
      #1;
      check("midreset_tx_high", int'(bus_f.oTx), 1);
      check("midreset_busy_low", int'(bus_f.oBusy), 0);
      check("midreset_addr", int'({bus_f.oResultRow, bus_f.oResultCol}), 0);
      tick();
      reset = 1'b0;
      c0 = cyc;
      expect_stream(c0, 8'hB1, 8'hFF);
    end
    bus_f.iStart = 1'b0;
    tick();

    // 434 clocks/bit: start-bit width and frame length
    mem = vecs[0].mem;
    reset_pulse();
    tick();
    bus_s.iStart = 1'b1;
    c0 = cyc;
`ifdef RESULT_TX_SYNC_HEADER_EN
    t0 = 2 + 20 * 434 + 9;
`else
    t0 = 10;
`endif
    t1 = t0 + 10 * 434 + 9;
    while (cyc < c0 + t0 - 1) tick();
    check("slow_idle_before_start", int'(bus_s.oTx), 1);
    tick();
    check("slow_start_low", int'(bus_s.oTx), 0);
    w = 0;
    while (bus_s.oTx === 1'b0 && w < 2000) begin
      w++;
      tick();
    end
    check("slow_start_width", w, 434);
    while (cyc < c0 + t1 - 1) tick();
    check("slow_gap_high", int'(bus_s.oTx), 1);
    tick();
    check("slow_next_start", int'(bus_s.oTx), 0);
    bus_s.iStart = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Reader at the far end of the binary result memory written by the thresholding stage.
- Once thresholding signals finished, scans the 1-bit result memory in raster order and packs 8 pixels per byte.
- Streams each byte over a UART 8N1 line to the host PC.
- Sits between the result memory read port and the board's TX pin.

Parameters:
- WIDTH_BITS, 8, column address width.
- HEIGHT_BITS, 8, row address width.
- WIDTH, 2**WIDTH_BITS, image width; must be a multiple of 8, so WIDTH_BITS >= 3.
- HEIGHT, 2**HEIGHT_BITS, image height.
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- iStart  in  1  level; tie to thresholding finished flag.
- oResultCol  out  WIDTH_BITS  result memory read column.
- oResultRow  out  HEIGHT_BITS  result memory read row.
- iResultData  in  1  result memory read data; valid 1 cycle after address (synchronous RAM).
- oTx  out  1  UART line, idle high.
- oBusy  out  1  high from leaving IDLE until entering DONE.
- oDone  out  1  high while in DONE.

Behaviour:
- Clocking: clock is the only clock; reset is asynchronous, active-high.
- Reset values: all state is reset, including mid-frame.
  - oTx=1, oBusy=0, oDone=0.
  - Address 0, FSM IDLE, shift/pack registers 0.
  - A reset mid-frame truncates the frame; the line returns high immediately.
- Address: pos counter of WIDTH_BITS+HEIGHT_BITS bits; col = low bits, row = high bits.
  - Outputs present pos in every state; pos is 0 in IDLE.
- FSM states IDLE, FETCH, SEND, DONE:
  - IDLE -> FETCH when iStart=1. oBusy rises the next cycle.
  - FETCH: 9 cycles.
    - Cycles 0..7 present addresses pos..pos+7 and increment pos each cycle.
    - Cycles 1..8 capture iResultData into the pack byte.
    - First pixel of the group goes to bit 7, the eighth to bit 0 (MSB-first packing, PBM P4 order).
  - SEND: one 8N1 frame of 10*CLKS_PER_BIT cycles.
    - Start bit 0, then data bits LSB-first, then stop bit 1.
    - oTx drops to 0 in the first SEND cycle.
    - Each bit is held exactly CLKS_PER_BIT cycles.
  - End of SEND, i.e. after the stop bit completes:
    - If the last group ended at address WIDTH*HEIGHT-1, go to DONE.
    - Otherwise go to FETCH.
  - DONE: oDone=1, oBusy=0, pos=0. DONE -> IDLE when iStart=0.
    - A held-high iStart therefore produces exactly one transmission.
- Boundaries:
  - iStart changes outside IDLE/DONE are ignored.
  - pos wraps to 0 after the final group without overflow side effects.
  - Total bytes = WIDTH*HEIGHT/8.
  - Inter-byte gap on the line = 9 idle-high cycles (the FETCH time).
- Bit timer: counts 0..CLKS_PER_BIT-1 using a counter of $clog2(CLKS_PER_BIT) bits; bit index counts 0..9.

Optional Feature:
- Macro: RESULT_TX_SYNC_HEADER_EN.
- Defined: after IDLE exit, send sync bytes 0xAA then 0x55 (two full frames, no FETCH) before the first image byte. Image ordering and timing are otherwise unchanged.
- Undefined: the first frame is image byte 0.

Decomposition:
- Shared package result_tx_pkg:
  - State enum (IDLE, FETCH, SEND, DONE, plus HDR0/HDR1 under the macro).
  - UART_START_BIT=0, UART_STOP_BIT=1, SYNC_BYTE0=8'hAA, SYNC_BYTE1=8'h55.
- One natural sub-module: uart_tx_byte.
  - Byte serializer: iValid/iData in, oReady out, oTx out, CLKS_PER_BIT parameter.
  - Accepts a byte only when oReady=1.
  - Top FSM drives it from SEND and the header states.

Test Plan (WIDTH_BITS=3, HEIGHT_BITS=1, CLKS_PER_BIT=4 unless noted):
- Reset with iStart=0 -> oTx=1, oBusy=0, oDone=0, col=0, row=0; nothing changes over 100 cycles.
- Memory row0=1,0,1,1,0,0,0,1 and row1 all 1s; iStart=1 -> UART decodes bytes 0xB1 then 0xFF; each frame 40 cycles, 9-cycle idle-high gap; oDone rises after the second stop bit.
- Bit timing with CLKS_PER_BIT=434: measure oTx low start-bit width -> exactly 434 cycles; full frame 4340 cycles.
- iStart held high after DONE -> no further frames; drop iStart for 1 cycle, raise again -> second identical transmission of 0xB1, 0xFF.
- Assert reset during data bit 3 of byte 0 -> oTx=1 and oBusy=0 in the same cycle (async); after release with iStart=1, transmission restarts from address 0.
- With RESULT_TX_SYNC_HEADER_EN defined -> decoded stream is 0xAA, 0x55, 0xB1, 0xFF, then oDone=1.
